// File: rtl/loader_pkg.sv
// Shared types and frame constants for the boot loader run-control sequencer.
package loader_pkg;
    typedef enum logic [2:0] {
        ST_WAIT_MAGIC,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_RESP,
        ST_RUN
    } state_t;

    localparam logic [7:0] MAGIC_DEF    = 8'h55;
    localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
    localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

    localparam int LEN_W = 16;
    localparam int IDX_W = 18;
    localparam int TO_W  = 32;
endpackage

// File: rtl/boot_loader_ctrl_if.sv
// Byte-stream RX/TX handshakes and BRAM port-A loader bus.
interface boot_loader_ctrl_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        sel_loader;
    logic [3:0]  ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_di;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        output rx_ready, tx_valid, tx_data, sel_loader, ld_we, ld_addr, ld_di
    );
    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  rx_ready, tx_valid, tx_data, sel_loader, ld_we, ld_addr, ld_di
    );
endinterface

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: loadable down-counter, expired when it has run down to zero.
module loader_timeout
    import loader_pkg::*;
#(
    parameter logic [TO_W-1:0] LOAD_VAL = 32'd999999
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_load,
    input  logic i_clr,
    output logic o_expired
);
    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == '0);
endmodule

// File: rtl/boot_loader_ctrl.sv
// Program-load sequencer: parses MAGIC/LEN/DATA/CSUM frames into IMEM, then releases the core.
module boot_loader_ctrl
    import loader_pkg::*;
#(
    parameter int         MAX_WORDS   = 4096,
    parameter logic [7:0] MAGIC       = MAGIC_DEF,
    parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF,
    parameter logic [7:0] NAK_BYTE    = NAK_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    boot_loader_ctrl_if.master bus,
    output logic               core_rst_n,
    output logic               busy,
    output logic               load_ok,
    output logic               load_err
);
    localparam logic [31:0]     MAXW    = MAX_WORDS;
    localparam logic [TO_W-1:0] TO_LOAD = TIMEOUT_CYC - 1;

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_csum;
    logic               r_ack;
    logic               r_tx_valid;
    logic [7:0]         r_tx_data;
    logic               r_core_rst_n;
    logic               r_sel_loader;
    logic [3:0]         r_ld_we;
    logic [31:0]        r_ld_addr;
    logic [31:0]        r_ld_di;
    logic               r_busy;
    logic               r_load_ok;
    logic               r_load_err;

    logic               w_rx_ready;
    logic               w_fire;
    logic               w_active;
    logic               w_expired;
    logic               w_to;
    logic               w_start;
    logic [LEN_W-1:0]   w_len;
    logic [IDX_W-1:0]   w_last;
    logic               w_ack;
    logic               w_nak;

    assign w_rx_ready = (r_state != ST_RESP);
    assign w_fire     = bus.rx_valid && w_rx_ready;
    assign w_active   = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                        (r_state == ST_DATA)   || (r_state == ST_CSUM);
    // A byte landing on the expiry cycle wins over the timeout.
    assign w_to       = w_expired && !w_fire;
    assign w_start    = w_fire && (bus.rx_data == MAGIC) &&
                        ((r_state == ST_WAIT_MAGIC) || (r_state == ST_RUN));
    assign w_len      = {bus.rx_data, r_len[7:0]};
    assign w_last     = {r_len, 2'b00} - 1'b1;
    assign w_ack      = (r_state == ST_CSUM) && w_fire && (bus.rx_data == r_csum);
    assign w_nak      = w_to ||
                        ((r_state == ST_LEN_HI) && w_fire && ({16'd0, w_len} > MAXW)) ||
                        ((r_state == ST_CSUM) && w_fire && (bus.rx_data != r_csum));

    loader_timeout #(.LOAD_VAL(TO_LOAD)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_active),
        .i_load    (w_fire),
        .i_clr     (!w_active),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_WAIT_MAGIC;
            r_len        <= '0;
            r_idx        <= '0;
            r_csum       <= '0;
            r_ack        <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
            r_core_rst_n <= 1'b0;
            r_sel_loader <= 1'b1;
            r_ld_we      <= '0;
            r_ld_addr    <= '0;
            r_ld_di      <= '0;
            r_busy       <= 1'b0;
            r_load_ok    <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_ld_we <= '0;
            if (w_start) begin
                r_core_rst_n <= 1'b0;
                r_sel_loader <= 1'b1;
                r_load_ok    <= 1'b0;
                r_load_err   <= 1'b0;
                r_busy       <= 1'b1;
                r_csum       <= '0;
                r_state      <= ST_LEN_LO;
            end else if (w_ack || w_nak) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_ack ? ACK_BYTE : NAK_BYTE;
                r_ack      <= w_ack;
                r_load_ok  <= w_ack;
                r_load_err <= w_nak;
                r_state    <= ST_RESP;
            end else begin
                case (r_state)
                    ST_LEN_LO: if (w_fire) begin
                        r_len[7:0] <= bus.rx_data;
                        r_state    <= ST_LEN_HI;
                    end
                    ST_LEN_HI: if (w_fire) begin
                        r_len   <= w_len;
                        r_idx   <= '0;
                        r_state <= (w_len == '0) ? ST_CSUM : ST_DATA;
                    end
                    ST_DATA: if (w_fire) begin
                        r_ld_we   <= 4'b0001 << r_idx[1:0];
                        r_ld_addr <= {14'd0, r_idx[17:2], 2'b00};
                        r_ld_di   <= {4{bus.rx_data}};
                        r_csum    <= r_csum ^ bus.rx_data;
                        r_idx     <= r_idx + 1'b1;
                        if (r_idx == w_last) r_state <= ST_CSUM;
                    end
                    ST_RESP: if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        if (r_ack) begin
                            r_core_rst_n <= 1'b1;
                            r_sel_loader <= 1'b0;
                            r_state      <= ST_RUN;
                        end else begin
                            r_state <= ST_WAIT_MAGIC;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready   = w_rx_ready;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.tx_data    = r_tx_data;
    assign bus.sel_loader = r_sel_loader;
    assign bus.ld_we      = r_ld_we;
    assign bus.ld_addr    = r_ld_addr;
    assign bus.ld_di      = r_ld_di;
    assign core_rst_n     = r_core_rst_n;
    assign busy           = r_busy;
    assign load_ok        = r_load_ok;
    assign load_err       = r_load_err;
endmodule
